// File: rtl/spec_ghr.sv
// spec_ghr: speculative / architectural global branch history register.
//
// ghr_spec is shifted on every accepted prediction, ghr_arch on every
// resolve. A small FIFO keeps the predicted direction of each in-flight
// branch so an in-order resolve can be checked against what was predicted.
// A mispredict or a flush rebuilds ghr_spec from the committed history and
// squashes everything still in flight.
//
// Optional feature: define SPEC_GHR_PERF_CNT_EN to build the saturating
// resolved / mispredict performance counters. Without it both counter
// outputs are tied to zero and no counter flops exist.
module spec_ghr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pred_valid,
  input  logic                         pred_taken,
  output logic                         pred_ready,
  input  logic                         resolve_valid,
  input  logic                         resolve_taken,
  input  logic                         flush,
  output logic [WIDTH-1:0]             ghr_spec,
  output logic [WIDTH-1:0]             ghr_arch,
  output logic                         mispredict,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic [15:0]                  perf_resolved,
  output logic [15:0]                  perf_mispred
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Architectural state
  logic [WIDTH-1:0] ghr_spec_q, ghr_spec_d;
  logic [WIDTH-1:0] ghr_arch_q, ghr_arch_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             mispredict_q, mispredict_d;
  logic             fifo_q [DEPTH];

  // Per-cycle decode
  logic pred_ready_s;
  logic pred_acc_s;
  logic pred_push_s;
  logic res_acc_s;
  logic pop_s;
  logic head_bit_s;
  logic mispred_s;
  logic squash_s;

  // Handshake decode: acceptance, head compare and squash condition.
  always_comb begin
    pred_ready_s = (count_q < DEPTH_C);
    pred_acc_s   = pred_valid & pred_ready_s;
    res_acc_s    = resolve_valid & (count_q != {CW{1'b0}});
    head_bit_s   = fifo_q[rd_ptr_q];
    mispred_s    = res_acc_s & (resolve_taken != head_bit_s);
    squash_s     = mispred_s | flush;
    // A squash makes any same-cycle prediction the youngest casualty.
    pred_push_s  = pred_acc_s & ~squash_s;
    // Entries are discarded wholesale on squash, so only a clean resolve pops.
    pop_s        = res_acc_s & ~squash_s;
  end

  // Next-state computation for histories, pointers and occupancy.
  always_comb begin
    ghr_arch_d   = ghr_arch_q;
    ghr_spec_d   = ghr_spec_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mispredict_d = mispred_s;

    if (res_acc_s) begin
      ghr_arch_d = {ghr_arch_q[WIDTH-2:0], resolve_taken};
    end else begin
      ghr_arch_d = ghr_arch_q;
    end

    if (squash_s) begin
      // Restart speculation from the committed history, including this
      // cycle's resolve.
      ghr_spec_d = ghr_arch_d;
      count_d    = {CW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
    end else begin
      if (pred_push_s) begin
        ghr_spec_d = {ghr_spec_q[WIDTH-2:0], pred_taken};
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end else begin
        ghr_spec_d = ghr_spec_q;
        wr_ptr_d   = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({pred_push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_spec_q   <= {WIDTH{1'b0}};
      ghr_arch_q   <= {WIDTH{1'b0}};
      count_q      <= {CW{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      mispredict_q <= 1'b0;
    end else begin
      ghr_spec_q   <= ghr_spec_d;
      ghr_arch_q   <= ghr_arch_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Predicted-direction storage, written at the tail on each push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 1'b0;
      end
    end else if (pred_push_s) begin
      fifo_q[wr_ptr_q] <= pred_taken;
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

`ifdef SPEC_GHR_PERF_CNT_EN
  logic [15:0] perf_res_q;
  logic [15:0] perf_mis_q;

  // Saturating event counters for resolves and mispredicts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_res_q <= 16'h0000;
      perf_mis_q <= 16'h0000;
    end else begin
      if (res_acc_s && (perf_res_q != 16'hFFFF)) begin
        perf_res_q <= perf_res_q + 16'h0001;
      end else begin
        perf_res_q <= perf_res_q;
      end
      if (mispred_s && (perf_mis_q != 16'hFFFF)) begin
        perf_mis_q <= perf_mis_q + 16'h0001;
      end else begin
        perf_mis_q <= perf_mis_q;
      end
    end
  end

  assign perf_resolved = perf_res_q;
  assign perf_mispred  = perf_mis_q;
`else
  assign perf_resolved = 16'h0000;
  assign perf_mispred  = 16'h0000;
`endif

  assign pred_ready = pred_ready_s;
  assign ghr_spec   = ghr_spec_q;
  assign ghr_arch   = ghr_arch_q;
  assign mispredict = mispredict_q;
  assign count      = count_q;
  assign empty      = (count_q == {CW{1'b0}});

endmodule
